// File: rtl/cpu_pkg.sv
// Shared definitions for the program sequencer: state encoding, opcode
// constants and a small opcode helper used by the fetch sequencer.
package cpu_pkg;

  // Sequencer states. PAUSE only becomes reachable in single-step builds.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    LOAD   = 3'd3,
    EXEC   = 3'd4,
    HALTED = 3'd5,
    ERROR  = 3'd6,
    PAUSE  = 3'd7
  } seq_state_t;

  // Opcodes live in the top three bits of every instruction word.
  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OPC_MOV  = 3'b000;
  localparam logic [OPC_W-1:0] OPC_MOVI = 3'b001;
  localparam logic [OPC_W-1:0] OPC_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OPC_SUB  = 3'b011;
  localparam logic [OPC_W-1:0] OPC_MOVO = 3'b100;
  localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

  // True when the opcode field matches the configured stop opcode.
  function automatic logic isStopOpcode(input logic [OPC_W-1:0] opcode,
                                        input logic [OPC_W-1:0] stopOpcode);
    return (opcode == stopOpcode);
  endfunction

  // States in which the sequencer is working on an instruction.
  function automatic logic isBusyState(input seq_state_t state);
    return (state == FETCH) || (state == WAIT) || (state == LOAD) ||
           (state == EXEC)  || (state == PAUSE);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Execution watchdog for the fetch sequencer. Counts cycles spent waiting
// for the control unit and flags when the last allowed cycle is reached.
module seq_watchdog
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // The counter never needs to hold more than TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles, saturating at the expiry value so it never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_seq.sv
// Program sequencer in front of the CPU control unit. Fetches instructions
// from a synchronous ROM at the program counter, loads them into the IR and
// runs the control unit until it reports Done, then advances the PC.
// Stops on the HALT opcode; raises err when the control unit stalls.
// Optional feature macro: SINGLE_STEP_EN adds i_step and the PAUSE state so
// that one instruction is executed per step request.
module instr_fetch_seq
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = 5,
  parameter int               INSTR_W  = 9,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_HALT,
  parameter int               TIMEOUT  = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
`ifdef SINGLE_STEP_EN
  input  logic               i_step,
`endif
  output logic               o_mem_rd,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic [INSTR_W-1:0] i_mem_rdata,
  output logic [INSTR_W-1:0] o_ir_data,
  output logic               o_ir_load,
  output logic               o_cpu_run,
  input  logic               i_cpu_done,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_busy,
  output logic               o_halted,
  output logic               o_err
);

  seq_state_t         r_state;
  seq_state_t         w_nextState;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pcNext;
  logic [INSTR_W-1:0] r_irData;
  logic [OPC_W-1:0]   w_opcode;
  logic               w_isHalt;
  logic               w_wdClear;
  logic               w_wdEnable;
  logic               w_wdExpired;

  assign w_opcode = r_irData[INSTR_W-1 -: OPC_W];
  assign w_isHalt = isStopOpcode(w_opcode, HALT_OPC);

  // Watchdog is cleared when an instruction is handed to the control unit
  // and counts every cycle the sequencer spends in EXEC.
  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_wdClear),
    .i_enable  (w_wdEnable),
    .o_expired (w_wdExpired)
  );

  // State, program counter and IR registers; the IR captures ROM data in
  // WAIT, the cycle after the read strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_irData <= '0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_pcNext;
      if (r_state == WAIT) begin
        r_irData <= i_mem_rdata;
      end
    end
  end

  // Next-state, PC update, watchdog control and Moore outputs decoded from
  // the registered state.
  always_comb begin
    w_nextState = r_state;
    w_pcNext    = r_pc;
    w_wdClear   = 1'b0;
    w_wdEnable  = 1'b0;
    o_mem_rd    = 1'b0;
    o_ir_load   = 1'b0;
    o_cpu_run   = 1'b0;
    o_halted    = 1'b0;
    o_err       = 1'b0;
    o_busy      = isBusyState(r_state);

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = FETCH;
          w_pcNext    = '0;
        end
      end

      FETCH: begin
        o_mem_rd    = 1'b1;
        w_nextState = WAIT;
      end

      WAIT: begin
        w_nextState = LOAD;
      end

      LOAD: begin
        if (w_isHalt) begin
          w_nextState = HALTED;
        end else begin
          o_ir_load   = 1'b1;
          w_wdClear   = 1'b1;
          w_nextState = EXEC;
        end
      end

      EXEC: begin
        o_cpu_run  = 1'b1;
        w_wdEnable = 1'b1;
        if (i_cpu_done) begin
          w_pcNext = r_pc + ADDR_W'(1);
`ifdef SINGLE_STEP_EN
          w_nextState = PAUSE;
`else
          w_nextState = FETCH;
`endif
        end else if (w_wdExpired) begin
          w_nextState = ERROR;
        end
      end

      HALTED: begin
        o_halted = 1'b1;
        if (i_start) begin
          w_nextState = FETCH;
          w_pcNext    = '0;
        end
      end

      ERROR: begin
        o_err = 1'b1;
        if (i_start) begin
          w_nextState = FETCH;
          w_pcNext    = '0;
        end
      end

`ifdef SINGLE_STEP_EN
      PAUSE: begin
        if (i_step) begin
          w_nextState = FETCH;
        end
      end
`endif

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign o_mem_addr = r_pc;
  assign o_pc       = r_pc;
  assign o_ir_data  = r_irData;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq. Table-driven program runs plus
// hand-written sequences for latency, timeout, reset-in-flight, PC wrap and
// (when SINGLE_STEP_EN is defined) single stepping.
module tb_instr_fetch_seq;

  localparam logic [8:0] I_MOV  = 9'b000_001_010;
  localparam logic [8:0] I_MOVI = 9'b001_000_111;
  localparam logic [8:0] I_ADD  = 9'b010_011_001;
  localparam logic [8:0] I_SUB  = 9'b011_010_100;
  localparam logic [8:0] I_MOVO = 9'b100_001_000;
  localparam logic [8:0] I_HALT = 9'b111_000_000;

  typedef struct packed {
    logic [4:0] pc;
    logic [8:0] ir;
  } exp_t;

  typedef struct {
    string      name;
    logic [35:0] prog;
    logic       never;
    int         delay;
    int         expLoads;
    logic [4:0] expPc;
    logic       expHalted;
    logic       expErr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, memRd, irLoad, cpuRun, cpuDone, busy, halted, err;
  logic [4:0] memAddr, pc;
  logic [8:0] memRdata, irData;
  logic       start2, memRd2, irLoad2, cpuRun2, cpuDone2, busy2, halted2, err2;
  logic [1:0] memAddr2, pc2;
  logic [8:0] memRdata2, irData2;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif

  logic [8:0] rom  [0:31];
  logic [8:0] rom2 [0:3];
  logic       cuNever, forceDone;
  int         cuDelay;
  int         runCnt, runCnt2;
  int         checks, errors;
  exp_t       expQ[$];
  logic [1:0] pcLog2[$];
  logic [8:0] irLog2[$];
  vec_t       vecs[7];

  instr_fetch_seq dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
`ifdef SINGLE_STEP_EN
    .i_step      (step),
`endif
    .o_mem_rd    (memRd),
    .o_mem_addr  (memAddr),
    .i_mem_rdata (memRdata),
    .o_ir_data   (irData),
    .o_ir_load   (irLoad),
    .o_cpu_run   (cpuRun),
    .i_cpu_done  (cpuDone),
    .o_pc        (pc),
    .o_busy      (busy),
    .o_halted    (halted),
    .o_err       (err)
  );

  instr_fetch_seq #(.ADDR_W(2)) dut2 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start2),
`ifdef SINGLE_STEP_EN
    .i_step      (1'b1),
`endif
    .o_mem_rd    (memRd2),
    .o_mem_addr  (memAddr2),
    .i_mem_rdata (memRdata2),
    .o_ir_data   (irData2),
    .o_ir_load   (irLoad2),
    .o_cpu_run   (cpuRun2),
    .i_cpu_done  (cpuDone2),
    .o_pc        (pc2),
    .o_busy      (busy2),
    .o_halted    (halted2),
    .o_err       (err2)
  );

  // Synchronous ROMs with one cycle of read latency.
  always @(posedge clk) begin
    if (memRd)  memRdata  <= rom[memAddr];
    if (memRd2) memRdata2 <= rom2[memAddr2];
  end

  // Control unit models: Done arrives a programmable number of cycles into run.
  always @(posedge clk) begin
    runCnt  <= cpuRun  ? runCnt + 1  : 0;
    runCnt2 <= cpuRun2 ? runCnt2 + 1 : 0;
  end
  assign cpuDone  = forceDone | (!cuNever && cpuRun && (runCnt == cuDelay));
  assign cpuDone2 = cpuRun2 && (runCnt2 == 1);

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every IR load must match the next expected (pc, instruction).
  always @(negedge clk) begin
    exp_t e;
    if (irLoad) begin
      if (expQ.size() == 0) begin
        checkOutput("sbUnexpectedLoad", {27'd0, pc}, 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("sbLoadPc", {27'd0, pc}, {27'd0, e.pc});
        checkOutput("sbLoadIr", {23'd0, irData}, {23'd0, e.ir});
      end
    end
    if (irLoad2) begin
      pcLog2.push_back(pc2);
      irLog2.push_back(irData2);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic [35:0] mk4(input logic [8:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic resetDut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic loadRom(input logic [35:0] prog);
    for (int i = 0; i < 32; i++) rom[i] = (i < 4) ? prog[i*9 +: 9] : I_HALT;
  endtask

  task automatic pushProg(input logic [35:0] prog, input int n);
    for (int i = 0; i < n; i++) expQ.push_back({5'(i), prog[i*9 +: 9]});
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitEnd(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (halted || err) break;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    resetDut();
    loadRom(v.prog);
    cuNever = v.never;
    cuDelay = v.delay;
    pushProg(v.prog, v.expLoads);
    pulseStart();
    waitEnd(400);
    checkOutput({v.name, "_pc"},     {27'd0, pc},    {27'd0, v.expPc});
    checkOutput({v.name, "_halted"}, {31'd0, halted}, {31'd0, v.expHalted});
    checkOutput({v.name, "_err"},    {31'd0, err},    {31'd0, v.expErr});
    checkOutput({v.name, "_busy"},   {31'd0, busy},   32'd0);
    checkOutput({v.name, "_loads"},  expQ.size(),     32'd0);
    expQ.delete();
  endtask

  initial begin
    int runCycles;
    int rdCount;
    logic seen;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; forceDone = 1'b0;
    cuNever = 1'b0; cuDelay = 2;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    for (int i = 0; i < 32; i++) rom[i] = I_HALT;
    rom2[0] = I_MOV; rom2[1] = I_MOVI; rom2[2] = I_ADD; rom2[3] = I_SUB;

    vecs[0] = '{"basic",       mk4(I_MOV, I_MOVI, I_ADD, I_HALT), 1'b0, 2,  3, 5'd3, 1'b1, 1'b0};
    vecs[1] = '{"haltFirst",   mk4(I_HALT, I_MOV, I_MOV, I_MOV),  1'b0, 2,  0, 5'd0, 1'b1, 1'b0};
    vecs[2] = '{"subMovo",     mk4(I_SUB, I_MOVO, I_HALT, I_ADD), 1'b0, 0,  2, 5'd2, 1'b1, 1'b0};
    vecs[3] = '{"timeout",     mk4(I_MOVI, I_HALT, I_HALT, I_HALT), 1'b1, 0, 1, 5'd0, 1'b0, 1'b1};
    vecs[4] = '{"doneAtLimit", mk4(I_ADD, I_HALT, I_HALT, I_HALT), 1'b0, 14, 1, 5'd1, 1'b1, 1'b0};
    vecs[5] = '{"doneLate",    mk4(I_ADD, I_HALT, I_HALT, I_HALT), 1'b0, 15, 1, 5'd0, 1'b0, 1'b1};
    vecs[6] = '{"haltOperand", mk4(I_MOV, 9'b111_101_010, I_ADD, I_ADD), 1'b0, 1, 1, 5'd1, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rstMemRd",  {31'd0, memRd},   32'd0);
    checkOutput("rstAddr",   {27'd0, memAddr}, 32'd0);
    checkOutput("rstIrData", {23'd0, irData},  32'd0);
    checkOutput("rstIrLoad", {31'd0, irLoad},  32'd0);
    checkOutput("rstRun",    {31'd0, cpuRun},  32'd0);
    checkOutput("rstPc",     {27'd0, pc},      32'd0);
    checkOutput("rstBusy",   {31'd0, busy},    32'd0);
    checkOutput("rstHalted", {31'd0, halted},  32'd0);
    checkOutput("rstErr",    {31'd0, err},     32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Start-to-run latency.
    resetDut();
    loadRom(vecs[0].prog);
    cuNever = 1'b0; cuDelay = 2;
    pushProg(vecs[0].prog, 3);
    pulseStart();
    checkOutput("latK1MemRd",  {31'd0, memRd},  32'd1);
    checkOutput("latK1Addr",   {27'd0, memAddr}, 32'd0);
    checkOutput("latK1IrLoad", {31'd0, irLoad}, 32'd0);
    @(negedge clk);
    checkOutput("latK2MemRd",  {31'd0, memRd},  32'd0);
    checkOutput("latK2IrLoad", {31'd0, irLoad}, 32'd0);
    @(negedge clk);
    checkOutput("latK3IrLoad", {31'd0, irLoad}, 32'd1);
    checkOutput("latK3Run",    {31'd0, cpuRun}, 32'd0);
    @(negedge clk);
    checkOutput("latK4Run",    {31'd0, cpuRun}, 32'd1);
    checkOutput("latK4IrLoad", {31'd0, irLoad}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("latK6Run",    {31'd0, cpuRun}, 32'd1);
    @(negedge clk);
    checkOutput("latK7Run",    {31'd0, cpuRun}, 32'd0);
    checkOutput("latK7MemRd",  {31'd0, memRd},  32'd1);
    checkOutput("latK7Pc",     {27'd0, pc},     32'd1);
    waitEnd(200);
    checkOutput("latFinalPc",  {27'd0, pc},     32'd3);
    expQ.delete();

    // Timeout length, then restart from ERROR.
    resetDut();
    loadRom(mk4(I_MOVI, I_HALT, I_HALT, I_HALT));
    cuNever = 1'b1;
    expQ.push_back({5'd0, I_MOVI});
    pulseStart();
    runCycles = 0;
    for (int c = 0; c < 100; c++) begin
      if (cpuRun) runCycles++;
      if (err) break;
      @(negedge clk);
    end
    checkOutput("toRunCycles", runCycles,       32'd15);
    checkOutput("toErr",       {31'd0, err},    32'd1);
    checkOutput("toPc",        {27'd0, pc},     32'd0);
    cuNever = 1'b0; cuDelay = 2;
    expQ.push_back({5'd0, I_MOVI});
    pulseStart();
    checkOutput("toRestartRd",   {31'd0, memRd},   32'd1);
    checkOutput("toRestartAddr", {27'd0, memAddr}, 32'd0);
    checkOutput("toRestartErr",  {31'd0, err},     32'd0);
    waitEnd(200);
    checkOutput("toRestartPc",   {27'd0, pc},      32'd1);
    checkOutput("toRestartHalt", {31'd0, halted},  32'd1);
    expQ.delete();

    // Reset while executing abandons the instruction; late Done is ignored.
    resetDut();
    loadRom(vecs[0].prog);
    cuNever = 1'b1;
    expQ.push_back({5'd0, I_MOV});
    pulseStart();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (cpuRun) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("rstExecSeen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstExecBusy", {31'd0, busy},   32'd0);
    checkOutput("rstExecRun",  {31'd0, cpuRun}, 32'd0);
    checkOutput("rstExecPc",   {27'd0, pc},     32'd0);
    forceDone = 1'b1;
    repeat (3) @(negedge clk);
    forceDone = 1'b0;
    checkOutput("lateDoneBusy", {31'd0, busy},  32'd0);
    checkOutput("lateDonePc",   {27'd0, pc},    32'd0);
    checkOutput("lateDoneRd",   {31'd0, memRd}, 32'd0);
    checkOutput("rstExecQueue", expQ.size(),    32'd0);
    expQ.delete();
    cuNever = 1'b0;

    // Two-bit PC wraps from 3 back to 0 and keeps fetching.
    pcLog2.delete(); irLog2.delete();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (pcLog2.size() >= 6) break;
      @(negedge clk);
    end
    checkOutput("wrapLoads", (pcLog2.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
    if (pcLog2.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("wrapPc%0d", i), {30'd0, pcLog2[i]}, i % 4);
        checkOutput($sformatf("wrapIr%0d", i), {23'd0, irLog2[i]}, {23'd0, rom2[i % 4]});
      end
    end
    checkOutput("wrapErr",  {31'd0, err2},  32'd0);
    checkOutput("wrapBusy", {31'd0, busy2}, 32'd1);
    resetDut();

`ifdef SINGLE_STEP_EN
    // Single step: the sequencer parks after each Done until stepped.
    step = 1'b0;
    resetDut();
    loadRom(vecs[0].prog);
    cuNever = 1'b0; cuDelay = 2;
    pushProg(vecs[0].prog, 3);
    pulseStart();
    for (int c = 0; c < 30; c++) begin
      if (cpuDone) break;
      @(negedge clk);
    end
    rdCount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (memRd) rdCount++;
    end
    checkOutput("pauseNoRead", rdCount,        32'd0);
    checkOutput("pauseBusy",   {31'd0, busy},  32'd1);
    checkOutput("pausePc",     {27'd0, pc},    32'd1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    rdCount = (memRd) ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (memRd) rdCount++;
    end
    checkOutput("stepOneFetch", rdCount,     32'd1);
    checkOutput("stepPc",       {27'd0, pc}, 32'd2);
    step = 1'b1;
    waitEnd(200);
    checkOutput("stepHalted",   {31'd0, halted}, 32'd1);
    checkOutput("stepQueue",    expQ.size(),     32'd0);
    expQ.delete();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
